// File: rtl/xor_stream_scrambler_pkg.sv
// Shared constants and mode encoding for the XOR stream scrambler family.
package scrambler_pkg;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci shift-left form
  localparam logic [15:0] TAPS_DEFAULT     = 16'hB400;
  localparam logic [15:0] SEED_RST_DEFAULT = 16'hACE1;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_LFSR   = 1'b1
  } mode_e;

endpackage

// File: rtl/xor_stream_scrambler_if.sv
// Valid/ready word stream with an end-of-frame marker.
interface xor_stream_scrambler_if #(
  parameter int unsigned DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/xor_stream_scrambler_lfsr_step_n.sv
// Combinational N-step advance of a Fibonacci shift-left LFSR.
module lfsr_step_n #(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(16'hB400),
  parameter int unsigned       N      = 8
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o
);

  // Unroll N single steps: shift left, feed back the tap parity into bit 0
  always_comb begin
    logic [LFSR_W-1:0] s;
    s = state_i;
    for (int unsigned i = 0; i < N; i++) begin
      s = {s[LFSR_W-2:0], ^(s & TAPS)};
    end
    state_o = s;
  end

endmodule

// File: rtl/xor_stream_scrambler.sv
// Streaming XOR scrambler: static key or LFSR keystream, one output register,
// keystream restarts from the seed register at every frame boundary.
module xor_stream_scrambler
  import scrambler_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(TAPS_DEFAULT),
  parameter logic [LFSR_W-1:0] SEED_RST = LFSR_W'(SEED_RST_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [DATA_W-1:0]    key,
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed_in,
  xor_stream_scrambler_if.slave  s,
  xor_stream_scrambler_if.master m
);

  logic [LFSR_W-1:0] seed_q, seed_d;
  logic [LFSR_W-1:0] state_q, state_d;
  logic [LFSR_W-1:0] state_step;
  logic [LFSR_W-1:0] seed_fix;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              s_ready;
  logic              accept;
  logic              lfsr_mode;
  logic [DATA_W-1:0] keystream;

  lfsr_step_n #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .N      (DATA_W)
  ) u_step (
    .state_i (state_q),
    .state_o (state_step)
  );

  // Single output register: accept whenever it is empty or being drained
  assign s_ready   = !m_valid_q || m.ready;
  assign accept    = s.valid && s_ready;
  assign lfsr_mode = (mode_e'(mode) == MODE_LFSR);
  assign keystream = lfsr_mode ? state_q[LFSR_W-1 -: DATA_W] : key;
  // An all-zero seed would lock the LFSR at zero
  assign seed_fix  = (seed_in == '0) ? SEED_RST : seed_in;

  // Seed/state next value: seed_load beats frame reload beats advance
  always_comb begin
    seed_d  = seed_q;
    state_d = state_q;
    if (seed_load) begin
      seed_d  = seed_fix;
      state_d = seed_fix;
    end else if (accept && s.last) begin
      state_d = seed_q;
    end else if (accept && lfsr_mode) begin
      state_d = state_step;
    end
  end

  // Output register next value: load on accept, drop valid once drained
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = s.data ^ keystream;
      m_last_d  = s.last;
    end else if (m.ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State, seed and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q    <= SEED_RST;
      state_q   <= SEED_RST;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      seed_q    <= seed_d;
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign s.ready = s_ready;
  assign m.valid = m_valid_q;
  assign m.data  = m_data_q;
  assign m.last  = m_last_q;

endmodule

// File: tb/tb_xor_stream_scrambler.sv
// Self-checking bench for xor_stream_scrambler: vector table, directed corner
// sequences, randomized traffic against a behavioural model, round-trip pair.
module tb_xor_stream_scrambler;
  import scrambler_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode;
  logic [DW-1:0] key;
  logic          seed_load;
  logic [LW-1:0] seed_in;

  logic          rt_mode;
  logic [DW-1:0] rt_key;
  logic          rt_seed_load;
  logic [LW-1:0] rt_seed_in;

  always #5 clk = ~clk;

  xor_stream_scrambler_if #(.DATA_W(DW)) if_in  ();
  xor_stream_scrambler_if #(.DATA_W(DW)) if_out ();
  xor_stream_scrambler_if #(.DATA_W(DW)) rt_a   ();
  xor_stream_scrambler_if #(.DATA_W(DW)) rt_b   ();
  xor_stream_scrambler_if #(.DATA_W(DW)) rt_c   ();

  xor_stream_scrambler #(.DATA_W(DW), .LFSR_W(LW)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .key(key), .seed_load(seed_load),
    .seed_in(seed_in), .s(if_in), .m(if_out)
  );

  xor_stream_scrambler #(.DATA_W(DW), .LFSR_W(LW)) u_scr (
    .clk(clk), .rst_n(rst_n), .mode(rt_mode), .key(rt_key), .seed_load(rt_seed_load),
    .seed_in(rt_seed_in), .s(rt_a), .m(rt_b)
  );

  xor_stream_scrambler #(.DATA_W(DW), .LFSR_W(LW)) u_des (
    .clk(clk), .rst_n(rst_n), .mode(rt_mode), .key(rt_key), .seed_load(rt_seed_load),
    .seed_in(rt_seed_in), .s(rt_b), .m(rt_c)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: seed, LFSR state, and the expected output register
  logic [LW-1:0] md_seed, md_state;
  logic          e_mvalid, e_mlast;
  logic [DW-1:0] e_mdata;

  typedef struct {
    logic          mode;
    logic [DW-1:0] key;
    logic [DW-1:0] data;
    logic          last;
    logic [DW-1:0] exp_data;
    logic          exp_last;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference keystream generator: n single shifts with tap parity into bit 0
  function automatic logic [LW-1:0] lfsr_adv(input logic [LW-1:0] st, input int n);
    logic [LW-1:0] r;
    r = st;
    for (int i = 0; i < n; i++) begin
      r = LW'({r, 1'b0}) | LW'($countones(r & TAPS_DEFAULT) % 2);
    end
    return r;
  endfunction

  task automatic model_reset();
    md_seed  = SEED_RST_DEFAULT;
    md_state = SEED_RST_DEFAULT;
    e_mvalid = 1'b0;
    e_mdata  = '0;
    e_mlast  = 1'b0;
  endtask

  // One clock of the main DUT: predict, clock, compare
  task automatic tick();
    logic          exp_rdy, acc, lin, mrdy;
    logic [DW-1:0] kk, din;
    logic [LW-1:0] nst, nsd;
    #1;
    exp_rdy = !e_mvalid || if_out.ready;
    check("s_ready", 32'(if_in.ready), 32'(exp_rdy));
    acc  = if_in.valid && exp_rdy;
    din  = if_in.data;
    lin  = if_in.last;
    mrdy = if_out.ready;
    kk   = mode ? md_state[LW-1 -: DW] : key;
    nst  = md_state;
    nsd  = md_seed;
    if (acc && lin) nst = md_seed;
    else if (acc && mode) nst = lfsr_adv(md_state, DW);
    if (seed_load) begin
      nsd = (seed_in == '0) ? SEED_RST_DEFAULT : seed_in;
      nst = nsd;
    end
    @(posedge clk);
    #1;
    md_state = nst;
    md_seed  = nsd;
    if (acc) begin
      e_mvalid = 1'b1;
      e_mdata  = din ^ kk;
      e_mlast  = lin;
    end else if (mrdy) begin
      e_mvalid = 1'b0;
    end
    check("m_valid", 32'(if_out.valid), 32'(e_mvalid));
    check("m_data", 32'(if_out.data), 32'(e_mdata));
    check("m_last", 32'(if_out.last), 32'(e_mlast));
    check("lfsr_state", 32'(u_dut.state_q), 32'(md_state));
  endtask

  task automatic beat(input logic md, input logic [DW-1:0] d, input logic l);
    mode         = md;
    if_in.valid  = 1'b1;
    if_in.data   = d;
    if_in.last   = l;
    if_out.ready = 1'b1;
    tick();
  endtask

  logic [DW-1:0] held;
  logic [LW-1:0] st_save;
  logic [DW-1:0] k_tmp;
  logic [DW:0]   rtq[$];
  logic [DW:0]   rt_exp;
  logic          in_acc, out_acc;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 8'hA5, 8'h3C, 1'b0, 8'h99, 1'b0};
    tbl[1] = '{1'b0, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    tbl[2] = '{1'b1, 8'h77, 8'h00, 1'b0, 8'hAC, 1'b0};
    tbl[3] = '{1'b1, 8'h77, 8'hFF, 1'b1, 8'h1E, 1'b1};
    tbl[4] = '{1'b1, 8'h77, 8'h00, 1'b0, 8'hAC, 1'b0};
    tbl[5] = '{1'b0, 8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0};
    tbl[6] = '{1'b1, 8'h77, 8'h5A, 1'b1, 8'hBB, 1'b1};
    tbl[7] = '{1'b1, 8'h77, 8'h3C, 1'b1, 8'h90, 1'b1};

    mode = 1'b0; key = '0; seed_load = 1'b0; seed_in = '0;
    if_in.valid = 1'b0; if_in.data = '0; if_in.last = 1'b0; if_out.ready = 1'b1;
    rt_mode = 1'b1; rt_key = 8'h5C; rt_seed_load = 1'b0; rt_seed_in = '0;
    rt_a.valid = 1'b0; rt_a.data = '0; rt_a.last = 1'b0; rt_c.ready = 1'b1;
    model_reset();

    // Reset state
    #12;
    check("rst_m_valid", 32'(if_out.valid), 32'd0);
    check("rst_m_data", 32'(if_out.data), 32'd0);
    check("rst_m_last", 32'(if_out.last), 32'd0);
    check("rst_s_ready", 32'(if_in.ready), 32'd1);
    check("rst_state", 32'(u_dut.state_q), 32'hACE1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table, full-throughput back-to-back beats
    for (int i = 0; i < 8; i++) begin
      key = tbl[i].key;
      beat(tbl[i].mode, tbl[i].data, tbl[i].last);
      check($sformatf("tbl%0d_data", i), 32'(if_out.data), 32'(tbl[i].exp_data));
      check($sformatf("tbl%0d_last", i), 32'(if_out.last), 32'(tbl[i].exp_last));
      if (i == 1) check("mode0_state_kept", 32'(u_dut.state_q), 32'hACE1);
    end
    if_in.valid = 1'b0;
    tick();
    check("valid_drops", 32'(if_out.valid), 32'd0);

    // Frame resync: 3-beat frame then a new frame restarts at the seed
    beat(1'b1, 8'h00, 1'b0);
    check("fr_b1_data", 32'(if_out.data), 32'hAC);
    check("fr_b1_last", 32'(if_out.last), 32'd0);
    beat(1'b1, 8'h00, 1'b0);
    check("fr_b2_data", 32'(if_out.data), 32'hE1);
    check("fr_b2_last", 32'(if_out.last), 32'd0);
    beat(1'b1, 8'h00, 1'b1);
    check("fr_b3_last", 32'(if_out.last), 32'd1);
    beat(1'b1, 8'h00, 1'b0);
    check("fr2_b1_data", 32'(if_out.data), 32'hAC);
    check("fr2_b1_last", 32'(if_out.last), 32'd0);

    // Backpressure: output held, no acceptance, no state advance
    beat(1'b1, 8'h11, 1'b0);
    held    = e_mdata;
    st_save = md_state;
    if_out.ready = 1'b0;
    if_in.data   = 8'h22;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_s_ready", 32'(if_in.ready), 32'd0);
      check("bp_hold", 32'(if_out.data), 32'(held));
      check("bp_state", 32'(u_dut.state_q), 32'(st_save));
    end
    k_tmp = st_save[LW-1 -: DW];
    beat(1'b1, 8'h22, 1'b0);
    check("bp_resume", 32'(if_out.data), 32'(8'h22 ^ k_tmp));
    beat(1'b1, 8'h33, 1'b1);
    if_in.valid = 1'b0;
    tick();

    // Seed loading: zero seed, explicit seed, load concurrent with a beat
    seed_load = 1'b1; seed_in = '0;
    tick();
    seed_load = 1'b0;
    check("seed0_state", 32'(u_dut.state_q), 32'hACE1);
    seed_load = 1'b1; seed_in = 16'h1234;
    tick();
    seed_load = 1'b0;
    beat(1'b1, 8'h00, 1'b0);
    check("seed_ks0", 32'(if_out.data), 32'h12);
    beat(1'b1, 8'h00, 1'b0);
    check("seed_ks1", 32'(if_out.data), 32'h34);
    k_tmp = lfsr_adv(16'h1234, 16) >> 8;
    seed_load = 1'b1; seed_in = 16'hBEEF;
    beat(1'b1, 8'h00, 1'b0);
    seed_load = 1'b0;
    check("seed_conc_old", 32'(if_out.data), 32'(k_tmp));
    beat(1'b1, 8'h00, 1'b0);
    check("seed_conc_new", 32'(if_out.data), 32'hBE);

    // Asynchronous reset mid-frame
    beat(1'b1, 8'h00, 1'b0);
    if_in.valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", 32'(if_out.valid), 32'd0);
    check("arst_state", 32'(u_dut.state_q), 32'hACE1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_no_beat", 32'(if_out.valid), 32'd0);
    beat(1'b1, 8'h00, 1'b0);
    check("arst_first_ks", 32'(if_out.data), 32'hAC);
    if_in.valid = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      mode         = 1'($urandom_range(0, 1));
      key          = DW'($urandom);
      if_in.valid  = ($urandom_range(0, 3) != 0);
      if_in.data   = DW'($urandom);
      if_in.last   = ($urandom_range(0, 3) == 0);
      if_out.ready = ($urandom_range(0, 2) != 0);
      seed_load    = ($urandom_range(0, 24) == 0);
      seed_in      = ($urandom_range(0, 1) == 0) ? '0 : LW'($urandom);
      tick();
    end
    seed_load = 1'b0;
    if_in.valid = 1'b0;
    if_out.ready = 1'b1;
    tick();

    // Round trip: scrambler followed by descrambler returns the input stream
    for (int i = 0; i < 520; i++) begin
      if (i < 500) begin
        rt_a.valid = ($urandom_range(0, 3) != 0);
        rt_a.data  = DW'($urandom);
        rt_a.last  = ($urandom_range(0, 4) == 0);
        rt_c.ready = ($urandom_range(0, 3) != 0);
      end else begin
        rt_a.valid = 1'b0;
        rt_c.ready = 1'b1;
      end
      #1;
      in_acc  = rt_a.valid && rt_a.ready;
      out_acc = rt_c.valid && rt_c.ready;
      if (in_acc) rtq.push_back({rt_a.last, rt_a.data});
      if (out_acc) begin
        if (rtq.size() == 0) begin
          check("rt_unexpected", 32'(rt_c.data), 32'hFFFF_FFFF);
        end else begin
          rt_exp = rtq.pop_front();
          check("rt_data", 32'(rt_c.data), 32'(rt_exp[DW-1:0]));
          check("rt_last", 32'(rt_c.last), 32'(rt_exp[DW]));
        end
      end
      @(posedge clk);
      #1;
    end
    check("rt_drained", 32'(rtq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
